mult_seq_ctrl: RTL and testbench

//  Sequential 32x32 multiplier for MULT/MULTU. Reuses one adder_32 instance for shift-add

---
 rtl/mult_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier for MULT/MULTU.
// A single shared adder handles operand absolute values, the 32 shift-add
// iterations and the final two-step 64-bit negate, so latency is fixed.

// Plain ripple-style adder; the only arithmetic datapath in the multiplier.
module adder_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;     // multiplicand, made absolute in ABS_A
  logic [WIDTH-1:0] b_reg;     // multiplier, made absolute in ABS_B
  // Upper accumulator. After each shift its top bit is the adder carry, so
  // the always-zero 33rd bit of the partial product is not stored.
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] lo_reg;    // working low word / multiplier shift register
  logic             sgn_reg;   // captured is_signed
  logic             neg_reg;   // product must be negated at the end
  logic             k_reg;     // carry from low-word negate into high word
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_out_reg;

  logic             accept;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] iter_s;
  logic             iter_c;

  // A new operation is taken whenever the unit is not mid-operation.
  assign accept = start && (state_reg == S_IDLE || state_reg == S_DONE);

  adder_32 #(.W(WIDTH)) u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Steer the shared adder according to the current step.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state_reg)
      S_ABS_A:  begin add_x = ~a_reg;   add_cin = 1'b1;  end
      S_ABS_B:  begin add_x = ~b_reg;   add_cin = 1'b1;  end
      S_ITER:   begin add_x = acc_reg;  add_y   = a_reg; end
      S_FIX_LO: begin add_x = ~lo_reg;  add_cin = 1'b1;  end
      S_FIX_HI: begin add_x = ~acc_reg; add_cin = k_reg; end
      default:  ;
    endcase
  end

  // Partial sum for one shift-add step: add the multiplicand only when the
  // current multiplier bit is set.
  always_comb begin
    iter_s = acc_reg;
    iter_c = 1'b0;
    if (lo_reg[0]) begin
      iter_s = add_sum;
      iter_c = add_cout;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: fixed walk through every step regardless of operands.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (accept) state_next = S_ABS_A;
      S_ABS_A:  state_next = S_ABS_B;
      S_ABS_B:  state_next = S_ITER;
      S_ITER:   if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = S_FIX_LO;
      S_FIX_LO: state_next = S_FIX_HI;
      S_FIX_HI: state_next = S_DONE;
      S_DONE:   state_next = accept ? S_ABS_A : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
    done = (state_reg == S_DONE);
  end

  // Datapath registers; reset clears everything so an aborted op leaves no trace.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      lo_reg     <= '0;
      sgn_reg    <= 1'b0;
      neg_reg    <= 1'b0;
      k_reg      <= 1'b0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_out_reg <= '0;
    end else begin
      case (state_reg)
        S_ABS_A: if (sgn_reg && a_reg[WIDTH-1]) a_reg <= add_sum;
        S_ABS_B: begin
          lo_reg  <= (sgn_reg && b_reg[WIDTH-1]) ? add_sum : b_reg;
          acc_reg <= '0;
          cnt_reg <= '0;
        end
        S_ITER: begin
          acc_reg <= {iter_c, iter_s[WIDTH-1:1]};
          lo_reg  <= {iter_s[0], lo_reg[WIDTH-1:1]};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        S_FIX_LO: begin
          if (neg_reg) begin
            lo_reg <= add_sum;
            k_reg  <= add_cout;
          end else begin
            k_reg  <= 1'b0;
          end
        end
        S_FIX_HI: begin
          hi_reg     <= neg_reg ? add_sum : acc_reg;
          lo_out_reg <= lo_reg;
        end
        default: ;
      endcase
      // Capture overrides nothing above: accept only happens in IDLE/DONE.
      if (accept) begin
        a_reg   <= op_a;
        b_reg   <= op_b;
        sgn_reg <= is_signed;
        neg_reg <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_out_reg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: directed corner cases, handshake,
// reset abort and a random run against a 64-bit reference product.
module tb_mult_seq_ctrl;

  localparam int LAT = 36;  // edges from the accepting edge to the edge entering DONE

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct {
    logic [63:0] prod;
    int unsigned t0;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb_v;
    if (s) begin
      sa   = $signed({{32{a[31]}}, a});
      sb_v = $signed({{32{b[31]}}, b});
      return sa * sb_v;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Output side of the scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (reset_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", {hi, lo}, e.prod);
        chk("latency", 64'(cyc - e.t0), 64'(LAT));
        $display("op a=%h b=%h signed=%0d -> hi=%h lo=%h", e.a, e.b, e.s, hi, lo);
      end
    end
  end

  task automatic wait_not_busy();
    int w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  // Drive one request and push its expected product at the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    wait_not_busy();
    start = 1'b1; op_a = a; op_b = b; is_signed = s;
    @(negedge clk);
    sb.push_back('{ref_mul(a, b, s), cyc, a, b, s});
    n_acc++;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || busy) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;

    // Directed cases; consecutive issues land in DONE and exercise back-to-back accept.
    issue(32'd7, 32'd9, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(32'h8000_0000, 32'd1, 1'b1);
    issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    issue(32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();

    // start held high while busy with changing operands: only the first counts.
    wait_not_busy();
    start = 1'b1; op_a = 32'd12345; op_b = 32'hFFFF_FF00; is_signed = 1'b1;
    @(negedge clk);
    sb.push_back('{ref_mul(32'd12345, 32'hFFFF_FF00, 1'b1), cyc, 32'd12345, 32'hFFFF_FF00, 1'b1});
    n_acc++;
    for (int i = 0; i < 10; i++) begin
      op_a = $urandom; op_b = $urandom; is_signed = ~is_signed;
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // Reset abort during the iteration phase (counter = 10).
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    sb.delete();
    n_acc--;
    @(negedge clk);
    reset_n = 1'b1;
    issue(32'hDEAD_BEEF, 32'h0000_0003, 1'b1);
    drain();

    // Random operands in both modes, with extreme values mixed in.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h8000_0000;
        1:       rb = 32'd0;
        default: rb = $urandom;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (3) @(negedge clk);

    chk("done_count", 64'(n_done), 64'(n_acc));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
